icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the fetch unit and the memory controller's instruction-side port. Hits return a 32-bit instruction one cycle after the request. Misses issue a single word request to the memory controller, fill the line and forward the word. It also supports pipeline flush, which discards an in-flight miss result without corrupting the array.

## Interface
- `INDEX_W`, 8: index bits; 2^INDEX_W one-word lines; tag = pc[`MEM_ADD_W`-1 : INDEX_W+2]
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: global enable; 0 freezes every register, outputs hold
- `iIF_En` in 1: fetch request pulse
- `iIF_Pc` in `MEM_ADD_W`: fetch address, word aligned (pc[1:0] ignored)
- `iIF_Flush` in 1: discard outstanding miss result
- `oIF_En` out 1: instruction valid pulse
- `oIF_Ins` out `INS_DAT_W`: instruction, held until next oIF_En
- `oMC_En` out 1: memory request pulse
- `oMC_Pc` out `MEM_ADD_W`: memory request address
- `iMC_En` in 1: memory response pulse
- `iMC_Ins` in `INS_DAT_W`: memory response word, valid when iMC_En=1

## Operation
- Array: valid[2^INDEX_W], tag[], data[]; index = pc[INDEX_W+1:2].
- States: IDLE, WAIT (one miss outstanding), REPLAY (pending request lookup).
- IDLE + iIF_En: hit (valid & tag match) -> oIF_En=1, oIF_Ins=data next cycle. Miss -> oMC_En=1, oMC_Pc={pc[31:2],2'b00} next cycle, latch pc, drop=0, go WAIT.
- WAIT + iMC_En: write valid=1, tag, data at latched index; if drop=0, oIF_En=1, oIF_Ins=iMC_Ins next cycle. Next state is REPLAY if pend=1, else IDLE.
- WAIT + iIF_Flush: drop<=1. A flush arriving in the same cycle as iMC_En still fills the line and suppresses oIF_En.
- WAIT + iIF_En: legal only when the same cycle or an earlier cycle of this WAIT had iIF_Flush. Store pend=1 and pendPc; a later iIF_En overwrites pendPc. iIF_En without a prior flush is a protocol error; the request is dropped.
- REPLAY: lookup of pendPc, pend<=0. Behaves exactly as IDLE + iIF_En, including issuing a miss. A new iIF_En in REPLAY overrides pendPc.
- iIF_Flush in IDLE/REPLAY: clears pend; has no other effect. An oIF_En already scheduled for the next cycle is still emitted; the fetcher discards it.
- Exactly one outstanding memory request; oMC_En is never asserted while in WAIT.
- iMC_En outside WAIT: ignored.

## Timing
- Reset: state=IDLE, all valid=0, drop=0, pend=0. oIF_En=0, oIF_Ins=0, oMC_En=0, oMC_Pc=0.
- Hit: request cycle T -> oIF_En at T+1 (1-cycle pulse).
- Miss: request T -> oMC_En at T+1. Response R -> array written at R edge, oIF_En at R+1. A same-index request at R+1 hits.
- Replay miss: response R -> REPLAY lookup R+1 -> oMC_En R+2.
- en=0 in any cycle stretches all latencies by that cycle. Pulses are not duplicated.
- rst mid-WAIT: returns to IDLE, and the response is discarded because the memory controller shares rst.

## Configuration
- `ICACHE_EN` defined: behaviour as above.
- `ICACHE_EN` undefined: no array; every lookup is a miss. The response is forwarded but not stored. Timing is identical to the miss path.

## Test plan
- Cold miss: iIF_Pc=0x100 -> oMC_En, oMC_Pc=0x100 at T+1. iMC_Ins=0x00500093 -> oIF_En, oIF_Ins=0x00500093 next cycle. Refetch 0x100 -> hit at T+1, no oMC_En.
- Conflict (INDEX_W=8): fill 0x100, then 0x500 (same index) -> miss; refetch 0x100 -> miss again.
- Flush + replay: miss 0x200, flush, iIF_Pc=0x104 (cached) during WAIT. Response arrives -> no oIF_En for 0x200; 0x200 is then a hit. 0x104 hit returned at R+2.
- Flush same cycle as iMC_En: line filled, oIF_En stays 0.
- Reset mid-WAIT, then request 0x200 -> miss with fresh oMC_En; no stale oIF_En.
- en held 0 for 3 cycles after request -> single oIF_En 3 cycles late. Built without `ICACHE_EN`: repeated 0x100 -> oMC_En every time.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and the memory controller's
// instruction port. One-word lines, one outstanding miss, flush/replay support.
// Build option: define ICACHE_EN to instantiate the valid/tag/data array;
// without it every lookup takes the miss path and responses are only forwarded.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no miss outstanding; iIF_En performs a lookup
// S_WAIT   | one memory request outstanding, waiting for iMC_En
// S_REPLAY | lookup of the request parked during WAIT (or a fresh one)
module icache #(
    parameter int INDEX_W   = 8,
    parameter int MEM_ADD_W = 32,
    parameter int INS_DAT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIF_En,
    input  logic [MEM_ADD_W-1:0] iIF_Pc,
    input  logic                 iIF_Flush,
    output logic                 oIF_En,
    output logic [INS_DAT_W-1:0] oIF_Ins,
    output logic                 oMC_En,
    output logic [MEM_ADD_W-1:0] oMC_Pc,
    input  logic                 iMC_En,
    input  logic [INS_DAT_W-1:0] iMC_Ins
);
    localparam int WORD_W = MEM_ADD_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPLAY} state_t;

    state_t               state_q, state_d;
    logic                 drop_q, drop_d;
    logic                 pend_q, pend_d;
    logic [WORD_W-1:0]    pend_pc_q, pend_pc_d;
    logic [WORD_W-1:0]    mc_word_q, mc_word_d;
    logic                 if_en_q, if_en_d;
    logic [INS_DAT_W-1:0] if_ins_q, if_ins_d;
    logic                 mc_en_q, mc_en_d;

    logic                 lk_req;
    logic [WORD_W-1:0]    lk_word;
    logic                 lk_hit;
    logic [INS_DAT_W-1:0] lk_data;
    logic                 fill_we;

    // Byte offset of the fetch address carries no information.
    logic unused_pc_bits;
    assign unused_pc_bits = ^iIF_Pc[1:0];

    // Lookup source: fresh request in IDLE, parked or overriding request in REPLAY.
    assign lk_req  = ((state_q == S_IDLE) && iIF_En) || (state_q == S_REPLAY);
    assign lk_word = ((state_q == S_REPLAY) && !iIF_En) ? pend_pc_q
                                                        : iIF_Pc[MEM_ADD_W-1:2];

`ifdef ICACHE_EN
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = WORD_W - INDEX_W;

    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [INS_DAT_W-1:0] data_q [LINES];
    logic [INDEX_W-1:0]   lk_idx;
    logic [INDEX_W-1:0]   fill_idx;

    assign lk_idx   = lk_word[INDEX_W-1:0];
    assign fill_idx = mc_word_q[INDEX_W-1:0];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_word[WORD_W-1:INDEX_W]);
    assign lk_data  = data_q[lk_idx];

    // Valid bits: cleared by reset, set when a miss response fills the line.
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else if (en && fill_we)
            valid_q[fill_idx] <= 1'b1;
    end

    // Tag/data storage, written at the latched miss index on response.
    always_ff @(posedge clk) begin
        if (en && fill_we) begin
            tag_q[fill_idx]  <= mc_word_q[WORD_W-1:INDEX_W];
            data_q[fill_idx] <= iMC_Ins;
        end
    end
`else
    logic unused_fill;
    assign unused_fill = fill_we;
    assign lk_hit      = 1'b0;
    assign lk_data     = '0;
`endif

    // Next-state and output pulse logic.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        mc_word_d = mc_word_q;
        if_ins_d  = if_ins_q;
        if_en_d   = 1'b0;
        mc_en_d   = 1'b0;
        fill_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iIF_Flush)
                    pend_d = 1'b0;
            end
            S_REPLAY: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_WAIT: begin
                if (iIF_Flush)
                    drop_d = 1'b1;
                // A request during WAIT is only accepted once fetch has flushed.
                if (iIF_En && (drop_q || iIF_Flush)) begin
                    pend_d    = 1'b1;
                    pend_pc_d = iIF_Pc[MEM_ADD_W-1:2];
                end
                if (iMC_En) begin
                    fill_we = 1'b1;
                    if (!(drop_q || iIF_Flush)) begin
                        if_en_d  = 1'b1;
                        if_ins_d = iMC_Ins;
                    end
                    state_d = pend_d ? S_REPLAY : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (lk_req) begin
            if (lk_hit) begin
                if_en_d  = 1'b1;
                if_ins_d = lk_data;
            end else begin
                mc_en_d   = 1'b1;
                mc_word_d = lk_word;
                drop_d    = 1'b0;
                state_d   = S_WAIT;
            end
        end
    end

    // Control registers; reset wins over en, en=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            drop_q    <= 1'b0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            mc_word_q <= '0;
            if_en_q   <= 1'b0;
            if_ins_q  <= '0;
            mc_en_q   <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            mc_word_q <= mc_word_d;
            if_en_q   <= if_en_d;
            if_ins_q  <= if_ins_d;
            mc_en_q   <= mc_en_d;
        end
    end

    // Pulses are masked while frozen so a held register is never seen twice.
    assign oIF_En  = if_en_q & en;
    assign oMC_En  = mc_en_q & en;
    assign oIF_Ins = if_ins_q;
    assign oMC_Pc  = {mc_word_q, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache. The model tracks cache contents as
// plain valid/tag tables (ignored when ICACHE_EN is undefined) and memory as a
// fixed hash of the word address; expected pulses carry the enabled-cycle count
// at which they must appear.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst, en, iIF_En, iIF_Flush, iMC_En;
    logic [31:0] iIF_Pc, iMC_Ins;
    logic        oIF_En, oMC_En;
    logic [31:0] oIF_Ins, oMC_Pc;

    always #5 clk = ~clk;

    icache #(.INDEX_W(8), .MEM_ADD_W(32), .INS_DAT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en),
        .iIF_En(iIF_En), .iIF_Pc(iIF_Pc), .iIF_Flush(iIF_Flush),
        .oIF_En(oIF_En), .oIF_Ins(oIF_Ins),
        .oMC_En(oMC_En), .oMC_Pc(oMC_Pc),
        .iMC_En(iMC_En), .iMC_Ins(iMC_Ins)
    );

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        exp_if[$];
    exp_t        exp_mc[$];
    int          checks = 0;
    int          errors = 0;
    int          ecnt = 0;
    bit          mc_seen = 1'b0;
    logic [31:0] last_ins = '0;
    int          force_stall = 0;
    bit          mval[256];
    logic [29:0] mtag[256];

    // Enabled-cycle counter: latencies are measured in cycles with en=1.
    always @(posedge clk) if (en) ecnt <= ecnt + 1;

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit m_hit(input logic [29:0] w);
        bit h;
        h = mval[w[7:0]] && (mtag[w[7:0]] == w);
`ifndef ICACHE_EN
        h = 1'b0;
`endif
        return h;
    endfunction

    function automatic void m_fill(input logic [29:0] w);
        mval[w[7:0]] = 1'b1;
        mtag[w[7:0]] = w;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 256; i++) mval[i] = 1'b0;
    endfunction

    function automatic void push_if(input logic [31:0] v, input int c);
        exp_t x;
        x.val = v; x.cyc = c;
        exp_if.push_back(x);
    endfunction

    function automatic void push_mc(input logic [29:0] w, input int c);
        exp_t x;
        x.val = {w, 2'b00}; x.cyc = c;
        exp_mc.push_back(x);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
            | 32'($urandom_range(0, 3));
        return p;
    endfunction

    // Monitor: pops and compares whenever the DUT presents a pulse.
    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            if (oIF_En) begin
                checks++;
                if (exp_if.size() == 0) begin
                    errors++;
                    $display("FAIL if_unexpected: got oIF_En ins=%h at cyc %0d, none expected", oIF_Ins, ecnt);
                end else begin
                    x = exp_if.pop_front();
                    if (oIF_Ins !== x.val || ecnt != x.cyc) begin
                        errors++;
                        $display("FAIL if_resp: got ins=%h cyc=%0d, expected ins=%h cyc=%0d",
                                 oIF_Ins, ecnt, x.val, x.cyc);
                    end
                    last_ins = x.val;
                end
            end else if (en) begin
                checks++;
                if (oIF_Ins !== last_ins) begin
                    errors++;
                    $display("FAIL if_hold: got ins=%h, expected held %h", oIF_Ins, last_ins);
                end
            end
            if (oMC_En) begin
                checks++;
                mc_seen = 1'b1;
                if (exp_mc.size() == 0) begin
                    errors++;
                    $display("FAIL mc_unexpected: got oMC_En pc=%h at cyc %0d, none expected", oMC_Pc, ecnt);
                end else begin
                    x = exp_mc.pop_front();
                    if (oMC_Pc !== x.val || ecnt != x.cyc) begin
                        errors++;
                        $display("FAIL mc_req: got pc=%h cyc=%0d, expected pc=%h cyc=%0d",
                                 oMC_Pc, ecnt, x.val, x.cyc);
                    end
                end
            end
        end
    end

    // One enabled cycle of stimulus, optionally preceded by en=0 cycles.
    task automatic step(input bit ifen, input logic [31:0] pc, input bit fl,
                        input bit mcen, input logic [31:0] ins, output int e);
        int n;
        n = force_stall;
        force_stall = 0;
        if (n == 0 && $urandom_range(0, 9) == 0) n = $urandom_range(1, 3);
        if (n > 0) begin
            en = 1'b0;
            repeat (n) @(posedge clk);
            #1;
        end
        en = 1'b1; iIF_En = ifen; iIF_Pc = pc; iIF_Flush = fl;
        iMC_En = mcen; iMC_Ins = ins;
        e = ecnt;
        @(posedge clk);
        #1;
        iIF_En = 1'b0; iIF_Flush = 1'b0; iMC_En = 1'b0;
    endtask

    task automatic idle();
        int e;
        step(1'b0, $urandom, 1'b0, 1'b0, $urandom, e);
    endtask

    task automatic wait_mc();
        int k;
        k = 0;
        while (!mc_seen && k < 20) begin
            idle();
            k++;
        end
        if (!mc_seen) begin
            checks++;
            errors++;
            $display("FAIL mc_timeout: got no oMC_En within %0d cycles, expected one", k);
        end
        mc_seen = 1'b0;
    endtask

    task automatic respond(input logic [29:0] w, input bit fl, output int r);
        repeat ($urandom_range(0, 2)) idle();
        step(1'b0, $urandom, fl, 1'b1, mem_word(w), r);
    endtask

    task automatic fetch(input logic [31:0] pc, input bit fl_resp, input int post_stall);
        logic [29:0] w;
        int          e, r;
        w = pc[31:2];
        mc_seen = 1'b0;
        step(1'b1, pc, 1'b0, 1'b0, $urandom, e);
        force_stall = post_stall;
        if (m_hit(w)) begin
            push_if(mem_word(w), e + 1);
        end else begin
            push_mc(w, e + 1);
            wait_mc();
            respond(w, fl_resp, r);
            m_fill(w);
            if (!fl_resp) push_if(mem_word(w), r + 1);
        end
    endtask

    // Miss on a, flush, park b (variants differ in how b is presented), then replay.
    task automatic replay(input logic [31:0] a, input logic [31:0] b1,
                          input logic [31:0] b, input int variant);
        logic [29:0] wa, wb;
        int          e, r, r2;
        wa = a[31:2];
        wb = b[31:2];
        if (m_hit(wa)) begin
            fetch(a, 1'b0, 0);
            fetch(b, 1'b0, 0);
            return;
        end
        mc_seen = 1'b0;
        step(1'b1, a, 1'b0, 1'b0, $urandom, e);
        push_mc(wa, e + 1);
        wait_mc();
        case (variant)
            0: step(1'b1, b, 1'b1, 1'b0, $urandom, e);
            1: begin
                step(1'b0, $urandom, 1'b1, 1'b0, $urandom, e);
                idle();
                step(1'b1, b, 1'b0, 1'b0, $urandom, e);
            end
            2: begin
                step(1'b1, b1, 1'b1, 1'b0, $urandom, e);
                step(1'b1, b, 1'b0, 1'b0, $urandom, e);
            end
            default: step(1'b1, b1, 1'b1, 1'b0, $urandom, e);
        endcase
        mc_seen = 1'b0;
        respond(wa, 1'b0, r);
        m_fill(wa);
        if (variant == 3) step(1'b1, b, 1'b0, 1'b0, $urandom, e);
        if (m_hit(wb)) begin
            push_if(mem_word(wb), r + 2);
            if (variant != 3) idle();
        end else begin
            push_mc(wb, r + 2);
            wait_mc();
            respond(wb, 1'b0, r2);
            m_fill(wb);
            push_if(mem_word(wb), r2 + 1);
        end
    endtask

    task automatic check_reset_outputs();
        checks += 4;
        if (oIF_En !== 1'b0) begin errors++; $display("FAIL rst_if_en: got %b, expected 0", oIF_En); end
        if (oIF_Ins !== 32'h0) begin errors++; $display("FAIL rst_if_ins: got %h, expected 0", oIF_Ins); end
        if (oMC_En !== 1'b0) begin errors++; $display("FAIL rst_mc_en: got %b, expected 0", oMC_En); end
        if (oMC_Pc !== 32'h0) begin errors++; $display("FAIL rst_mc_pc: got %h, expected 0", oMC_Pc); end
    endtask

    task automatic do_reset();
        en = 1'b1; iIF_En = 1'b0; iIF_Flush = 1'b0; iMC_En = 1'b0;
        rst = 1'b1;
        last_ins = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        check_reset_outputs();
    endtask

    // Reset while a miss is outstanding; the response never arrives.
    task automatic reset_mid(input logic [31:0] a);
        int e;
        mc_seen = 1'b0;
        step(1'b1, a, 1'b0, 1'b0, $urandom, e);
        if (m_hit(a[31:2])) begin
            push_if(mem_word(a[31:2]), e + 1);
            idle();
        end else begin
            push_mc(a[31:2], e + 1);
            wait_mc();
        end
        repeat ($urandom_range(0, 2)) idle();
        do_reset();
        checks += 2;
        if (exp_if.size() != 0) begin errors++; $display("FAIL rst_if_pending: got %0d left, expected 0", exp_if.size()); end
        if (exp_mc.size() != 0) begin errors++; $display("FAIL rst_mc_pending: got %0d left, expected 0", exp_mc.size()); end
        exp_if.delete();
        exp_mc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rst = 1'b1; en = 1'b1; iIF_En = 1'b0; iIF_Pc = '0; iIF_Flush = 1'b0;
        iMC_En = 1'b0; iMC_Ins = '0;
        m_clear();
        repeat (3) @(posedge clk);
        do_reset();

        fetch(32'h100, 1'b0, 0);
        fetch(32'h100, 1'b0, 0);
        fetch(32'h500, 1'b0, 0);
        fetch(32'h100, 1'b0, 0);
        fetch(32'h104, 1'b0, 0);
        replay(32'h200, 32'h0, 32'h104, 0);
        fetch(32'h200, 1'b0, 0);
        fetch(32'h300, 1'b1, 0);
        fetch(32'h300, 1'b0, 0);
        fetch(32'h100, 1'b0, 3);
        reset_mid(32'h200);
        fetch(32'h200, 1'b0, 0);

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 9);
            if (k < 5)       fetch(rand_pc(), 1'b0, 0);
            else if (k < 8)  replay(rand_pc(), rand_pc(), rand_pc(), $urandom_range(0, 3));
            else if (k == 8) fetch(rand_pc(), 1'b1, 0);
            else             reset_mid(rand_pc());
        end

        repeat (5) idle();
        checks += 2;
        if (exp_if.size() != 0) begin errors++; $display("FAIL end_if_pending: got %0d left, expected 0", exp_if.size()); end
        if (exp_mc.size() != 0) begin errors++; $display("FAIL end_mc_pending: got %0d left, expected 0", exp_mc.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
